// File: rtl/sbox_column_feeder_if.sv
// Handshake and BRAM bus bundle for sbox_column_feeder.
// The slave modport is the feeder's view; master is the AES datapath, consumer and BRAM side.
interface sbox_column_feeder_if #(
  parameter int unsigned NBYTES = 4,
  parameter int unsigned SEL_W  = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [8*NBYTES-1:0]       in_data;
  logic [SEL_W*NBYTES-1:0]   in_sel;
  logic                      out_valid;
  logic                      out_ready;
  logic [8*NBYTES-1:0]       out_data;
  logic                      bram_en;
  logic [SEL_W+7:0]          bram_addra;
  logic [SEL_W+7:0]          bram_addrb;
  logic [7:0]                bram_doa;
  logic [7:0]                bram_dob;
  logic                      busy;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, bram_doa, bram_dob,
    output in_ready, out_valid, out_data, bram_en, bram_addra, bram_addrb, busy
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready, bram_doa, bram_dob,
    input  in_ready, out_valid, out_data, bram_en, bram_addra, bram_addrb, busy
  );
endinterface

// File: rtl/sbox_column_feeder.sv
// Feeds one masked 32-bit column through a dual-port two-cycle S-box BRAM.
// Optional macro SBOX_FEED_ZEROIZE_EN clears addresses, input latch and output after use.
module sbox_column_feeder #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned SEL_W  = 2
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    sbox_column_feeder_if.slave   feed_if
);

    localparam int unsigned DW = 8 * NBYTES;
    localparam int unsigned SW = SEL_W * NBYTES;
    localparam int unsigned AW = SEL_W + 8;

    typedef enum logic [2:0] {
        IDLE, ISS0, ISS1, CAP0, CAP1, HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addra_q, addra_d;
    logic [AW-1:0]   addrb_q, addrb_d;
    logic [DW-1:0]   out_q, out_d;
    logic            in_ready_q, out_valid_q, en_q, busy_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (feed_if.in_valid && in_ready_q) begin
                    state_d = ISS0;
                    data_d  = feed_if.in_data;
                    sel_d   = feed_if.in_sel;
                end
            end
            ISS0: state_d = ISS1;
            ISS1: state_d = CAP0;
            CAP0: begin
                state_d     = CAP1;
                out_d[7:0]  = feed_if.bram_doa;
                out_d[15:8] = feed_if.bram_dob;
`ifdef SBOX_FEED_ZEROIZE_EN
                data_d = '0;
                sel_d  = '0;
`endif
            end
            CAP1: begin
                state_d      = HOLD;
                out_d[23:16] = feed_if.bram_doa;
                out_d[31:24] = feed_if.bram_dob;
            end
            HOLD: begin
                if (feed_if.out_ready) begin
                    state_d = IDLE;
`ifdef SBOX_FEED_ZEROIZE_EN
                    out_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Addresses are registered, so they are loaded for the state being entered;
    // ISS0 is only entered from the accept edge, hence the direct use of the inputs.
    always_comb begin
`ifdef SBOX_FEED_ZEROIZE_EN
        addra_d = '0;
        addrb_d = '0;
`else
        addra_d = addra_q;
        addrb_d = addrb_q;
`endif
        if (state_d == ISS0) begin
            addra_d = {feed_if.in_sel[1:0], feed_if.in_data[7:0]};
            addrb_d = {feed_if.in_sel[3:2], feed_if.in_data[15:8]};
        end else if (state_d == ISS1) begin
            addra_d = {sel_q[5:4], data_q[23:16]};
            addrb_d = {sel_q[7:6], data_q[31:24]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            data_q      <= '0;
            sel_q       <= '0;
            addra_q     <= '0;
            addrb_q     <= '0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            addra_q     <= addra_d;
            addrb_q     <= addrb_d;
            out_q       <= out_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == HOLD);
            en_q        <= (state_d == ISS0) || (state_d == ISS1) ||
                           (state_d == CAP0) || (state_d == CAP1);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign feed_if.in_ready   = in_ready_q;
    assign feed_if.out_valid  = out_valid_q;
    assign feed_if.out_data   = out_q;
    assign feed_if.bram_en    = en_q;
    assign feed_if.bram_addra = addra_q;
    assign feed_if.bram_addrb = addrb_q;
    assign feed_if.busy       = busy_q;

endmodule

// File: tb/tb_sbox_column_feeder.sv
// Directed bench for sbox_column_feeder with a two-cycle registered BRAM model.
module tb_sbox_column_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    sbox_column_feeder_if #(.NBYTES(4), .SEL_W(2)) bus ();

    sbox_column_feeder #(.NBYTES(4), .SEL_W(2)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .feed_if (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] sbox_f(input logic [9:0] a);
        return a[7:0] ^ {6'b0, a[9:8]};
    endfunction

    logic [7:0] ma_q, mb_q;
    always @(posedge clk) begin
        if (bus.bram_en) begin
            ma_q         <= sbox_f(bus.bram_addra);
            mb_q         <= sbox_f(bus.bram_addrb);
            bus.bram_doa <= ma_q;
            bus.bram_dob <= mb_q;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  32'(bus.in_ready),   32'd1);
        check({tag, "_out_valid"}, 32'(bus.out_valid),  32'd0);
        check({tag, "_out_data"},  bus.out_data,        32'd0);
        check({tag, "_addra"},     32'(bus.bram_addra), 32'd0);
        check({tag, "_addrb"},     32'(bus.bram_addrb), 32'd0);
        check({tag, "_en"},        32'(bus.bram_en),    32'd0);
        check({tag, "_busy"},      32'(bus.busy),       32'd0);
    endtask

    initial begin
        int last;
        int n_acc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b0;

        // reset state
        step();
        step();
        check_reset("rst");
        rst_n = 1'b1;
        step();
        check_reset("post_rst");

        // c0: basic lookup, then hold in_valid high with 0xFFFFFFFF while busy
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3322_1100;
        bus.in_sel   = 8'hE4;
        step();
        bus.in_data = 32'hFFFF_FFFF;
        check("c1_addra", 32'(bus.bram_addra), 32'h000);
        check("c1_addrb", 32'(bus.bram_addrb), 32'h111);
        check("c1_en",    32'(bus.bram_en),    32'd1);
        check("c1_busy",  32'(bus.busy),       32'd1);
        check("c1_ready", 32'(bus.in_ready),   32'd0);
        step();
        check("c2_addra", 32'(bus.bram_addra), 32'h222);
        check("c2_addrb", 32'(bus.bram_addrb), 32'h333);
        step();
        check("c3_valid", 32'(bus.out_valid),  32'd0);
        check("c3_en",    32'(bus.bram_en),    32'd1);
        step();
        check("c4_valid", 32'(bus.out_valid),  32'd0);
        check("c4_ready", 32'(bus.in_ready),   32'd0);
        step();
        check("c5_valid", 32'(bus.out_valid),  32'd1);
        check("c5_data",  bus.out_data,        32'h3020_1000);
        check("c5_en",    32'(bus.bram_en),    32'd0);

        // backpressure
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data",  bus.out_data,       32'h3020_1000);
            check("bp_ready", 32'(bus.in_ready),  32'd0);
            check("bp_busy",  32'(bus.busy),      32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("rel_ready", 32'(bus.in_ready),  32'd1);
        check("rel_busy",  32'(bus.busy),      32'd0);
        check("rel_valid", 32'(bus.out_valid), 32'd0);
`ifdef SBOX_FEED_ZEROIZE_EN
        check("rel_data_zero", bus.out_data, 32'h0);
`else
        check("rel_data_keep", bus.out_data, 32'h3020_1000);
`endif

        // second column (0xFFFFFFFF still offered) accepted now
        step();
        bus.in_valid = 1'b0;
        check("c1b_addra", 32'(bus.bram_addra), 32'h0FF);
        check("c1b_addrb", 32'(bus.bram_addrb), 32'h1FF);
        step();
        check("c2b_addra", 32'(bus.bram_addra), 32'h2FF);
        check("c2b_addrb", 32'(bus.bram_addrb), 32'h3FF);
        for (int i = 3; i <= 5; i++) begin
            step();
`ifdef SBOX_FEED_ZEROIZE_EN
            check("zz_addra", 32'(bus.bram_addra), 32'h000);
            check("zz_addrb", 32'(bus.bram_addrb), 32'h000);
`else
            check("hold_addra", 32'(bus.bram_addra), 32'h2FF);
            check("hold_addrb", 32'(bus.bram_addrb), 32'h3FF);
`endif
        end
        check("c5b_valid", 32'(bus.out_valid), 32'd1);
        check("c5b_data",  bus.out_data,       32'hFCFD_FEFF);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // reset mid-operation in c3
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3322_1100;
        bus.in_sel   = 8'hE4;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_novalid", 32'(bus.out_valid), 32'd0);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hAABB_CCDD;
        bus.in_sel   = 8'h1B;
        step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        check("after_abort_valid", 32'(bus.out_valid), 32'd1);
        check("after_abort_data",  bus.out_data,       32'hAABA_CEDE);
        bus.out_ready = 1'b1;
        step();

        // back-to-back with out_ready tied high
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3322_1100;
        bus.in_sel   = 8'hE4;
        last  = -1;
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.in_ready) begin
                if (last >= 0) check("b2b_gap", 32'(k - last), 32'd6);
                last = k;
                n_acc++;
            end
            if (bus.out_valid) check("b2b_data", bus.out_data, 32'h3020_1000);
            step();
        end
        check("b2b_count", 32'(n_acc), 32'd4);
        bus.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_column_feeder.md
# sbox_column_feeder

- Controller between the masked AES datapath and one dual-port masked S-box BRAM.
- BRAM geometry: 10-bit address, 8-bit data, two-cycle registered read.
- Accepts one 32-bit masked column plus a 2-bit table select per byte.
- Issues the four lookups over both BRAM ports in two cycles, then collects the registered read data and returns the substituted 32-bit column over a valid/ready handshake.

## Interface
- NBYTES, 4, bytes per column; the logic is written for 4.
- SEL_W, 2, table-select bits per byte; BRAM address = {sel, byte}.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  column offered.
- in_ready  out  1  block can accept a column; registered.
- in_data  in  32  masked column; byte i = in_data[8i+7:8i].
- in_sel  in  8  table select; byte i uses in_sel[2i+1:2i].
- bram_en  out  1  drives BRAM ENA/ENB/REGCEA/REGCEB.
- bram_addra  out  10  BRAM port-A address; registered.
- bram_addrb  out  10  BRAM port-B address; registered.
- bram_doa  in  8  BRAM port-A read data.
- bram_dob  in  8  BRAM port-B read data.
- out_valid  out  1  substituted column available.
- out_ready  in  1  consumer takes the column.
- out_data  out  32  byte i = S-box result for input byte i.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISS0, ISS1, CAP0, CAP1, HOLD. One transition per clock, except that HOLD waits.
- IDLE: in_ready=1. An in_valid&in_ready handshake latches in_data and in_sel, then goes to ISS0.
- ISS0: bram_addra={sel0,byte0}, bram_addrb={sel1,byte1}, bram_en=1. Next state ISS1.
- ISS1: bram_addra={sel2,byte2}, bram_addrb={sel3,byte3}, bram_en=1. Next state CAP0.
- CAP0: bram_en=1. At the closing edge, out_data[7:0]<=bram_doa and out_data[15:8]<=bram_dob. Next state CAP1.
- CAP1: bram_en=1. At the closing edge, out_data[23:16]<=bram_doa and out_data[31:24]<=bram_dob. Next state HOLD.
- HOLD: out_valid=1 and out_data is stable. On out_ready the next state is IDLE; otherwise it stays in HOLD indefinitely.
- in_ready is 0 in every non-IDLE state, so no new column is accepted while busy.
- in_valid while busy is ignored and not queued.
- bram_en is 0 in IDLE and HOLD. The BRAM output register therefore freezes outside a lookup.
- The block never drives BRAM write enables or the BRAM reset; the integration ties those inactive.
- Asynchronous reset mid-operation:
  - Immediate return to IDLE; the in-flight column is discarded.
  - Any stale BRAM output is ignored, because it is captured only in CAP0 and CAP1.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, bram_addra=0, bram_addrb=0, bram_en=0, busy=0.
- Accept edge at the end of cycle c0. Then ISS0=c1, ISS1=c2, CAP0=c3, CAP1=c4, and out_valid=1 from c5.
- Latency from accept to out_valid is 5 cycles.
- A handshake in HOLD during cycle cN gives in_ready=1 in cN+1.
- Minimum column period is 6 cycles.
- No combinational path from any input to any output.

## Configuration
- Macro: SBOX_FEED_ZEROIZE_EN.
- Defined:
  - bram_addra and bram_addrb are driven to 0 in every state other than ISS0 and ISS1.
  - The latched input column and select are cleared to 0 on entry to CAP1.
  - out_data is cleared to 0 on the output handshake.
  - Purpose: masked values do not linger on address or data nets.
- Undefined: addresses, the input latch and out_data hold their last values until overwritten. This gives smaller area and less switching.

## Test plan
- Bench BRAM model: two-cycle registered read, mem[a] = a[7:0] ^ {6'b0, a[9:8]}, gated by bram_en.
- Scenario 1 — basic lookup: reset, then in_data=0x33221100, in_sel=0xE4.
  - Addresses 0x000/0x111 in c1 and 0x222/0x333 in c2.
  - out_valid in c5 with out_data=0x30201000.
- Scenario 2 — backpressure: hold out_ready=0 for 10 cycles.
  - out_valid and out_data stay stable.
  - in_ready=0 and busy=1 throughout.
  - Release: handshake, then in_ready=1 the next cycle.
- Scenario 3 — busy input ignored: in_valid held high with 0xFFFFFFFF during c1..c5 of the first column.
  - Only one column is accepted.
  - The second column is accepted only after the output handshake, and its result is 0xFCFDFEFF when in_sel=0xE4.
- Scenario 4 — reset mid-operation: assert rst low in c3.
  - All outputs take their reset values immediately.
  - out_valid is never asserted for the aborted column.
  - A following column completes correctly.
- Scenario 5 — back-to-back columns with out_ready tied high: successive accepts are exactly 6 cycles apart.
- Scenario 6 — zeroize, with SBOX_FEED_ZEROIZE_EN defined:
  - Addresses are 0 in c3..c5.
  - out_data becomes 0 the cycle after the handshake.
  - When undefined, out_data keeps 0x30201000.
